// File: rtl/cmac_issue_ctrl.sv
// -----------------------------------------------------------------------------
// cmac_issue_ctrl
//
// Initiator for the cmac multiply unit. Operand pairs are loaded into a local
// buffer. On start the pairs are streamed to cmac, one per cycle that cmac
// reports ready-for-data. The products come back in issue order and are
// collected into a result buffer, which is read out once the run has finished.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   load_en/load_data/load_weight  write one operand pair at the load pointer
//   len, start                     pair count for the run (sampled on start), go
//   busy, done, err                run in progress, completion pulse, sticky error
//   cmac_data/cmac_weight/cmac_nd  operand port to cmac (nd = one-cycle strobe)
//   cmac_rfd                       cmac ready for data
//   cmac_result/cmac_rdy           product from cmac and its valid strobe
//   res_rd/res_data/res_valid      result buffer pop / head entry / entry available
// -----------------------------------------------------------------------------
module cmac_issue_ctrl #(
  parameter int DEPTH   = 32,
  parameter int DW      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_en,
  input  logic [DW-1:0]          load_data,
  input  logic [DW-1:0]          load_weight,
  input  logic [$clog2(DEPTH):0] len,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [DW-1:0]          cmac_data,
  output logic [DW-1:0]          cmac_weight,
  output logic                   cmac_nd,
  input  logic                   cmac_rfd,
  input  logic [DW-1:0]          cmac_result,
  input  logic                   cmac_rdy,
  input  logic                   res_rd,
  output logic [DW-1:0]          res_data,
  output logic                   res_valid
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Storage: operand pairs and collected products
  logic [DW-1:0] data_mem   [DEPTH];
  logic [DW-1:0] weight_mem [DEPTH];
  logic [DW-1:0] res_mem    [DEPTH];

  state_t        state_reg, state_next;
  logic [CW-1:0] load_cnt_reg, load_cnt_next;
  logic [CW-1:0] issue_cnt_reg, issue_cnt_next;
  logic [CW-1:0] recv_cnt_reg, recv_cnt_next;
  logic [CW-1:0] rd_cnt_reg, rd_cnt_next;
  logic [CW-1:0] len_reg, len_next;
  logic [TW-1:0] idle_cnt_reg, idle_cnt_next;
  logic          err_reg, err_next;
  logic          done_reg;
  logic          cmac_nd_reg;
  logic [DW-1:0] cmac_data_reg, cmac_weight_reg;

  logic          busy_int;
  logic          res_valid_int;
  logic          err_set, err_clr;
  logic          op_we;
  logic [AW-1:0] op_waddr;
  logic [CW-1:0] load_base;
  logic          issue_fire;
  logic          res_we;

  assign busy_int      = (state_reg == ISSUE) || (state_reg == DRAIN);
  assign res_valid_int = (state_reg == IDLE) && (rd_cnt_reg < recv_cnt_reg);

  always_comb begin
    state_next     = state_reg;
    load_cnt_next  = load_cnt_reg;
    issue_cnt_next = issue_cnt_reg;
    recv_cnt_next  = recv_cnt_reg;
    rd_cnt_next    = rd_cnt_reg;
    len_next       = len_reg;
    idle_cnt_next  = idle_cnt_reg;
    err_set        = 1'b0;
    err_clr        = 1'b0;
    op_we          = 1'b0;
    op_waddr       = '0;
    issue_fire     = 1'b0;
    res_we         = 1'b0;

    // DONE rewinds the load pointer; a load arriving in that same cycle lands
    // at entry 0 of the fresh buffer.
    load_base     = (state_reg == DONE) ? '0 : load_cnt_reg;
    load_cnt_next = load_base;
    if (load_en) begin
      if (busy_int || (load_base == CW'(DEPTH))) begin
        err_set = 1'b1;
      end else begin
        op_we         = 1'b1;
        op_waddr      = load_base[AW-1:0];
        load_cnt_next = load_base + CW'(1);
      end
    end

    if (res_rd && res_valid_int) begin
      rd_cnt_next = rd_cnt_reg + CW'(1);
    end

    // Products are accepted only while a run is active and still owed
    // results; anything else is a protocol error and is discarded.
    if (cmac_rdy) begin
      if (busy_int && (recv_cnt_reg < len_reg)) begin
        res_we        = 1'b1;
        recv_cnt_next = recv_cnt_reg + CW'(1);
      end else begin
        err_set = 1'b1;
      end
    end

    case (state_reg)
      IDLE: begin
        if (start) begin
          // load_cnt_next already includes a load made in this same cycle
          if (len <= load_cnt_next) begin
            len_next       = len;
            issue_cnt_next = '0;
            recv_cnt_next  = '0;
            rd_cnt_next    = '0;
            idle_cnt_next  = '0;
            err_clr        = 1'b1;
            state_next     = (len == '0) ? DONE : ISSUE;
          end else begin
            err_set = 1'b1;
          end
        end
      end

      ISSUE: begin
        idle_cnt_next = '0;
        if (cmac_rfd && (issue_cnt_reg < len_reg)) begin
          issue_fire     = 1'b1;
          issue_cnt_next = issue_cnt_reg + CW'(1);
        end
        if (issue_cnt_next == len_reg) begin
          state_next = DRAIN;
        end
      end

      DRAIN: begin
        if (recv_cnt_next == len_reg) begin
          state_next = DONE;
        end else if (cmac_rdy) begin
          idle_cnt_next = '0;
        end else if (idle_cnt_reg == TW'(TIMEOUT - 1)) begin
          // this is the TIMEOUT-th consecutive cycle without a product
          err_set    = 1'b1;
          state_next = DONE;
        end else begin
          idle_cnt_next = idle_cnt_reg + TW'(1);
        end
      end

      DONE: begin
        state_next = IDLE;
      end
    endcase

    // A new error in the same cycle as an accepted start still sticks
    err_next = err_set | (err_reg & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      load_cnt_reg    <= '0;
      issue_cnt_reg   <= '0;
      recv_cnt_reg    <= '0;
      rd_cnt_reg      <= '0;
      len_reg         <= '0;
      idle_cnt_reg    <= '0;
      err_reg         <= 1'b0;
      done_reg        <= 1'b0;
      cmac_nd_reg     <= 1'b0;
      cmac_data_reg   <= '0;
      cmac_weight_reg <= '0;
    end else begin
      state_reg     <= state_next;
      load_cnt_reg  <= load_cnt_next;
      issue_cnt_reg <= issue_cnt_next;
      recv_cnt_reg  <= recv_cnt_next;
      rd_cnt_reg    <= rd_cnt_next;
      len_reg       <= len_next;
      idle_cnt_reg  <= idle_cnt_next;
      err_reg       <= err_next;
      // the pulse follows the DONE state by one cycle
      done_reg      <= (state_reg == DONE);
      cmac_nd_reg   <= issue_fire;
      if (issue_fire) begin
        cmac_data_reg   <= data_mem[issue_cnt_reg[AW-1:0]];
        cmac_weight_reg <= weight_mem[issue_cnt_reg[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (op_we) begin
      data_mem[op_waddr]   <= load_data;
      weight_mem[op_waddr] <= load_weight;
    end
  end

  always_ff @(posedge clk) begin
    if (res_we) begin
      res_mem[recv_cnt_reg[AW-1:0]] <= cmac_result;
    end
  end

  assign busy        = busy_int;
  assign done        = done_reg;
  assign err         = err_reg;
  assign cmac_nd     = cmac_nd_reg;
  assign cmac_data   = cmac_data_reg;
  assign cmac_weight = cmac_weight_reg;
  assign res_valid   = res_valid_int;
  assign res_data    = res_mem[rd_cnt_reg[AW-1:0]];

endmodule

// File: tb/tb_cmac_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cmac_issue_ctrl
//
// Directed bench for cmac_issue_ctrl. A behavioural cmac sits on the negative
// clock edge: it drives cmac_rfd (steady or toggling), logs every cmac_nd
// strobe with its operands and cycle number, and returns a product two cycles
// after each strobe. The directed sequence then checks the logs, the control
// outputs and the result buffer contents.
// -----------------------------------------------------------------------------
module tb_cmac_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_en = 1'b0;
  logic [15:0] load_data = '0;
  logic [15:0] load_weight = '0;
  logic [5:0]  len = '0;
  logic        start = 1'b0;
  logic        busy, done, err;
  logic [15:0] cmac_data, cmac_weight;
  logic        cmac_nd;
  logic        cmac_rfd = 1'b1;
  logic [15:0] cmac_result = '0;
  logic        cmac_rdy = 1'b0;
  logic        res_rd = 1'b0;
  logic [15:0] res_data;
  logic        res_valid;

  cmac_issue_ctrl #(.DEPTH(32), .DW(16), .TIMEOUT(255)) dut (
    .clk         (clk),
    .rst         (rst),
    .load_en     (load_en),
    .load_data   (load_data),
    .load_weight (load_weight),
    .len         (len),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .cmac_data   (cmac_data),
    .cmac_weight (cmac_weight),
    .cmac_nd     (cmac_nd),
    .cmac_rfd    (cmac_rfd),
    .cmac_result (cmac_result),
    .cmac_rdy    (cmac_rdy),
    .res_rd      (res_rd),
    .res_data    (res_data),
    .res_valid   (res_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // fp16 products for the four reference pairs: 1*2=2, 3*4=12, 5*6=30, 7*8=56.
  // Any other pair gets an arbitrary but deterministic mixing value.
  function automatic logic [15:0] mdl_prod(input logic [15:0] d, input logic [15:0] w);
    case ({d, w})
      32'h3C00_4000: return 16'h4000;
      32'h4200_4400: return 16'h4A00;
      32'h4500_4600: return 16'h4F80;
      32'h4700_4800: return 16'h5300;
      default:       return d ^ {w[7:0], w[15:8]};
    endcase
  endfunction

  // ---------------- behavioural cmac ----------------
  logic        pv0 = 1'b0, pv1 = 1'b0;
  logic [15:0] pd0 = '0, pd1 = '0;
  int          mdl_pushed = 0;
  int          mdl_stop_at = 32'h3FFF_FFFF;
  logic        rfd_toggle = 1'b0;
  logic        inj_rdy = 1'b0;
  int          bad_rfd = 0;
  logic [15:0] nd_d_q[$];
  logic [15:0] nd_w_q[$];
  int          nd_c_q[$];

  always @(negedge clk) begin
    if (rst) begin
      pv0      = 1'b0;
      pv1      = 1'b0;
      cmac_rdy = 1'b0;
    end else begin
      // cmac_rfd still holds the value the DUT sampled on the last edge
      if (cmac_nd && !cmac_rfd) bad_rfd++;
      if (cmac_nd) begin
        nd_d_q.push_back(cmac_data);
        nd_w_q.push_back(cmac_weight);
        nd_c_q.push_back(cyc);
      end
      cmac_rdy    = pv1 | inj_rdy;
      cmac_result = pv1 ? pd1 : 16'hDEAD;
      pv1 = pv0;
      pd1 = pd0;
      pv0 = cmac_nd && (mdl_pushed < mdl_stop_at);
      pd0 = mdl_prod(cmac_data, cmac_weight);
      if (pv0) mdl_pushed++;
    end
    cmac_rfd = rfd_toggle ? ~cmac_rfd : 1'b1;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_pair(input logic [15:0] d, input logic [15:0] w);
    load_en     = 1'b1;
    load_data   = d;
    load_weight = w;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic do_start(input logic [5:0] l, output int t);
    t     = cyc;
    start = 1'b1;
    len   = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, output int dc);
    dc = -1;
    for (int i = 0; i < max; i++) begin
      if (done) begin
        dc = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic read_check(input string tag, input logic [15:0] exp);
    chk({tag, "_valid"}, res_valid, 1);
    chk(tag, res_data, exp);
    res_rd = 1'b1;
    @(negedge clk);
    res_rd = 1'b0;
  endtask

  logic [15:0] pa_d [4];
  logic [15:0] pa_w [4];
  logic [15:0] pa_r [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, dc, base, bbase;
    pa_d = '{16'h3C00, 16'h4200, 16'h4500, 16'h4700};
    pa_w = '{16'h4000, 16'h4400, 16'h4600, 16'h4800};
    pa_r = '{16'h4000, 16'h4A00, 16'h4F80, 16'h5300};

    // ---- reset state ----
    rst = 1'b1;
    tick(3);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_nd", cmac_nd, 0);
    chk("rst_data", cmac_data, 0);
    chk("rst_weight", cmac_weight, 0);
    chk("rst_res_valid", res_valid, 0);
    rst = 1'b0;
    tick(1);

    // ---- A: 4 pairs, rfd steady high ----
    for (int i = 0; i < 4; i++) load_pair(pa_d[i], pa_w[i]);
    base = nd_d_q.size();
    do_start(6'd4, t);
    chk("A_busy", busy, 1);
    wait_done(100, dc);
    chk("A_done_seen", (dc >= 0), 1);
    tick(1);
    chk("A_done_one_cycle", done, 0);
    chk("A_nd_count", nd_d_q.size() - base, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("A_nd_data%0d", i), nd_d_q[base+i], pa_d[i]);
      chk($sformatf("A_nd_weight%0d", i), nd_w_q[base+i], pa_w[i]);
      chk($sformatf("A_nd_cycle%0d", i), nd_c_q[base+i] - t, 2 + i);
    end
    chk("A_err", err, 0);
    chk("A_busy_after", busy, 0);
    for (int i = 0; i < 4; i++) read_check($sformatf("A_res%0d", i), pa_r[i]);
    chk("A_res_empty", res_valid, 0);

    // ---- B: same run, rfd toggling ----
    for (int i = 0; i < 4; i++) load_pair(pa_d[i], pa_w[i]);
    base  = nd_d_q.size();
    bbase = bad_rfd;
    rfd_toggle = 1'b1;
    do_start(6'd4, t);
    wait_done(200, dc);
    rfd_toggle = 1'b0;
    chk("B_done_seen", (dc >= 0), 1);
    chk("B_nd_count", nd_d_q.size() - base, 4);
    chk("B_nd_without_rfd", bad_rfd - bbase, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("B_nd_data%0d", i), nd_d_q[base+i], pa_d[i]);
      chk($sformatf("B_nd_weight%0d", i), nd_w_q[base+i], pa_w[i]);
    end
    tick(1);
    for (int i = 0; i < 4; i++) read_check($sformatf("B_res%0d", i), pa_r[i]);
    chk("B_res_empty", res_valid, 0);

    // ---- C: len beyond load count, then len=0 ----
    load_pair(16'h1234, 16'h5678);
    load_pair(16'h9ABC, 16'hDEF0);
    base = nd_d_q.size();
    do_start(6'd3, t);
    tick(3);
    chk("C_busy_stays_low", busy, 0);
    chk("C_err_set", err, 1);
    chk("C_no_nd", nd_d_q.size() - base, 0);
    do_start(6'd0, t);
    wait_done(10, dc);
    chk("C_len0_done_cycle", dc - t, 2);
    chk("C_len0_err_cleared", err, 0);
    chk("C_len0_no_nd", nd_d_q.size() - base, 0);
    chk("C_len0_res_empty", res_valid, 0);
    tick(1);

    // ---- D: full buffer, overflow load, len=32 ----
    for (int i = 0; i < 32; i++) load_pair(16'h1000 + 16'(i), 16'h2000 + 16'(3 * i));
    chk("D_err_before_overflow", err, 0);
    load_pair(16'hBEEF, 16'hCAFE);
    chk("D_overflow_err", err, 1);
    base = nd_d_q.size();
    do_start(6'd32, t);
    wait_done(300, dc);
    chk("D_done_seen", (dc >= 0), 1);
    chk("D_nd_count", nd_d_q.size() - base, 32);
    chk("D_err_cleared", err, 0);
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("D_nd_data%0d", i), nd_d_q[base+i], 16'h1000 + 16'(i));
      chk($sformatf("D_nd_weight%0d", i), nd_w_q[base+i], 16'h2000 + 16'(3 * i));
    end
    tick(1);
    for (int i = 0; i < 32; i++)
      read_check($sformatf("D_res%0d", i), mdl_prod(16'h1000 + 16'(i), 16'h2000 + 16'(3 * i)));
    chk("D_res_empty", res_valid, 0);

    // ---- E: only 2 of 3 products return -> timeout ----
    for (int i = 0; i < 3; i++) load_pair(pa_d[i], pa_w[i]);
    mdl_stop_at = mdl_pushed + 2;
    do_start(6'd3, t);
    wait_done(400, dc);
    mdl_stop_at = 32'h3FFF_FFFF;
    chk("E_timeout_done_cycle", dc - t, 262);
    chk("E_timeout_err", err, 1);
    tick(1);
    for (int i = 0; i < 2; i++) read_check($sformatf("E_res%0d", i), pa_r[i]);
    chk("E_res_empty", res_valid, 0);
    do_start(6'd0, t);
    wait_done(10, dc);
    chk("E_len0_err_cleared", err, 0);
    inj_rdy = 1'b1;
    tick(2);
    inj_rdy = 1'b0;
    tick(1);
    chk("E_late_rdy_err", err, 1);
    chk("E_late_rdy_dropped", res_valid, 0);

    // ---- F: reset in ISSUE after 2 issues ----
    for (int i = 0; i < 4; i++) load_pair(pa_d[i], pa_w[i]);
    do_start(6'd4, t);
    tick(2);
    rst = 1'b1;
    tick(1);
    chk("F_rst_nd", cmac_nd, 0);
    chk("F_rst_busy", busy, 0);
    chk("F_rst_res_valid", res_valid, 0);
    chk("F_rst_err", err, 0);
    tick(1);
    rst = 1'b0;
    tick(1);
    load_pair(pa_d[0], pa_w[0]);
    load_pair(pa_d[1], pa_w[1]);
    base = nd_d_q.size();
    do_start(6'd2, t);
    wait_done(100, dc);
    chk("F_done_seen", (dc >= 0), 1);
    chk("F_nd_count", nd_d_q.size() - base, 2);
    chk("F_err", err, 0);
    tick(1);
    read_check("F_res0", pa_r[0]);
    read_check("F_res1", pa_r[1]);
    chk("F_res_empty", res_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
